adpll_hop_seq: RTL and testbench
================================

// Module: adpll_hop_seq
// PURPOSE
//  Channel-hop sequencer for the ADPLL. On a start pulse it drives the ADPLL CPU register
//  port as bus master: disable, program FCW and mode, enable, then poll LOCK/SAT until lock,
//  saturation or timeout. Sits between the radio MAC and the ADPLL control registers so
//  software does not bit-bang a hop.
// PARAMETERS
//  ADDR_W       5     ADPLL register address width (matches ADPLL_ADDR_W)
//  DATA_W       32    register write-data width (matches ADPLL_DATA_W)
//  FCWW         26    FCW width
//  SETTLE_CYC   64    cycles between EN=1 write ack and first LOCK poll (>=1)
//  POLL_GAP     8     idle cycles between successive LOCK polls (>=1)
//  TIMEOUT_CYC  4096  max cycles from EN=1 ack to lock before timeout error (>SETTLE_CYC)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset (synchronous, active-high)
//  start        in   1       1-cycle request; ignored while busy
//  abort        in   1       cancel hop in progress
//  fcw_in       in   FCWW    target channel FCW, sampled on accepted start
//  mode_in      in   2       adpll_mode to program, sampled on accepted start
//  busy         out  1       hop in progress
//  done         out  1       1-cycle pulse at end of every hop, success or fail
//  locked       out  1       last hop reached lock (sticky until next start)
//  sat_err      out  1       last hop ended on SAT=1
//  tmo_err      out  1       last hop timed out
//  lock_cycles  out  16      cycles from EN ack to lock read, saturates 0xFFFF
//  m_valid      out  1       ADPLL port request
//  m_address    out  ADDR_W  register address (ADPLL_EN, FCW, ADPLL_MODE, ADPLL_LOCK, ADPLL_SAT)
//  m_wdata      out  DATA_W  write data, zero-extended
//  m_wstrb      out  1       1 = write, 0 = read
//  m_rdata      in   2       read data; bit0 valid when m_ready=1
//  m_ready      in   1       ADPLL ack (registered copy of m_valid, 1-cycle latency)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  - Reset: all outputs 0, m_address/m_wdata 0, FSM IDLE, counters 0.
//  - Bus access: assert m_valid with stable addr/wdata/wstrb; complete on first cycle
//    m_ready=1 (capture m_rdata[0] for reads); drop m_valid next cycle; hold one RECOVER cycle
//    (ack still high) before any new access. Accesses never overlap. Min 3 cycles/access.
//  - FSM: IDLE -start-> WR_DIS(EN=0) -> WR_FCW -> WR_MODE -> WR_EN(EN=1) -> SETTLE
//    (SETTLE_CYC) -> RD_SAT -> RD_LOCK -> {lock: DONE_OK | else GAP(POLL_GAP) -> RD_SAT}.
//    RD_SAT read 1 -> FAIL_SAT. Timeout counter starts at WR_EN ack; reaching TIMEOUT_CYC ->
//    FAIL_TMO, evaluated only at access boundaries (no access cut mid-handshake).
//    FAIL_* -> WR_OFF(EN=0) -> DONE. DONE_OK -> DONE. DONE: done=1 one cycle, busy=0 -> IDLE.
//  - busy=1 from cycle after accepted start through DONE cycle exclusive.
//  - start while busy ignored; start and abort same cycle in IDLE: start wins, abort ignored.
//  - abort while busy: finish current access incl. RECOVER, then WR_OFF -> DONE; locked=0,
//    sat_err=0, tmo_err=0. abort in IDLE no effect.
//  - Status flags cleared on accepted start, set at DONE; exactly one or none set.
//  - lock_cycles: 16-bit counter, +1/cycle from EN ack to lock read ack, saturating.
//  - rst mid-hop: immediate return to reset state, m_valid=0 next edge; ADPLL left as is.
//  - Timeout counter width = $clog2(TIMEOUT_CYC+1); no wrap.
// STRUCTURE
//  - Register address codes shared from adpll_defines.vh (ADPLL_EN, FCW, ADPLL_MODE,
//    ADPLL_LOCK, ADPLL_SAT); FSM state codes as localparams here.
//  - Sub-module adpll_bus_master: single-access engine (req/we/addr/wdata in, ack/rbit out)
//    implementing the valid/ready/RECOVER protocol; FSM issues one access at a time.
// TESTING
//  - Nominal: start, fcw_in=26'h2620000, mode=1; model locks 200 cycles after EN -> write
//    order EN=0,FCW=2620000,MODE=1,EN=1; done pulse, locked=1, lock_cycles~200.
//  - Timeout: TIMEOUT_CYC=512, LOCK never set -> tmo_err=1, final write EN=0, done once.
//  - Saturation: SAT=1 on 3rd poll -> sat_err=1, locked=0, WR_OFF issued, no further polls.
//  - Abort mid WR_FCW: FCW write completes, then EN=0, done, all flags 0; start during busy
//    ignored (no sampling of new fcw_in).
//  - Handshake: slave ready delayed/held; assert no new m_valid during RECOVER, addr/wdata
//    stable while m_valid=1, max one access outstanding.
//  - rst asserted in GAP: next cycle busy=0, m_valid=0, flags 0; new start hops normally.

Source files
------------

// File: rtl/adpll_hop_seq_pkg.sv
// Shared types and ADPLL register address codes for the channel-hop sequencer.
package adpll_hop_seq_pkg;

  localparam logic [4:0] AdpllEnAddr   = 5'd0;
  localparam logic [4:0] FcwAddr       = 5'd1;
  localparam logic [4:0] AdpllModeAddr = 5'd2;
  localparam logic [4:0] AdpllLockAddr = 5'd3;
  localparam logic [4:0] AdpllSatAddr  = 5'd4;

  typedef enum logic [3:0] {
    StIdle,
    StWrDis,
    StWrFcw,
    StWrMode,
    StWrEn,
    StSettle,
    StRdSat,
    StRdLock,
    StGap,
    StWrOff,
    StDone
  } hop_state_e;

  typedef enum logic [1:0] {
    ResNone,
    ResLock,
    ResSat,
    ResTmo
  } hop_res_e;

  typedef enum logic [1:0] {
    BmIdle,
    BmWait,
    BmRecover
  } bm_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adpll_bus_master.sv
// Single-access engine for the ADPLL register port: valid/ready handshake followed by one
// RECOVER cycle; ack pulses in that RECOVER cycle with the captured read bit.
module adpll_bus_master
  import adpll_hop_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              rbit,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wstrb,
  input  logic              m_rbit,
  input  logic              m_ready
);

  bm_state_e         state_q, state_d;
  logic              valid_q, we_q, rbit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    unique case (state_q)
      BmIdle:    if (req) state_d = BmWait;
      BmWait:    if (m_ready) state_d = BmRecover;
      BmRecover: begin
        ack     = 1'b1;
        state_d = BmIdle;
      end
      default:   state_d = BmIdle;
    endcase
  end

  // New requests are only taken in BmIdle, so a request held high through RECOVER
  // cannot start an overlapping access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BmIdle;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rbit_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BmIdle && req) begin
        valid_q <= 1'b1;
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end else if (state_q == BmWait && m_ready) begin
        valid_q <= 1'b0;
        rbit_q  <= m_rbit;
      end
    end
  end

  assign rbit      = rbit_q;
  assign m_valid   = valid_q;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = we_q;

endmodule

// File: rtl/adpll_hop_seq.sv
// ADPLL channel-hop sequencer: disable, program FCW/mode, enable, then poll SAT/LOCK until
// lock, saturation, timeout or abort, driving the ADPLL register port as bus master.
module adpll_hop_seq
  import adpll_hop_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FCWW        = 26,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FCWW-1:0]   fcw_in,
  input  logic [1:0]        mode_in,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              sat_err,
  output logic              tmo_err,
  output logic [15:0]       lock_cycles,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wstrb,
  input  logic [1:0]        m_rdata,
  input  logic              m_ready
);

  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned WaitMax = (SETTLE_CYC > POLL_GAP) ? SETTLE_CYC : POLL_GAP;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  hop_state_e        state_q, state_d;
  hop_res_e          res_q, res_d;
  logic [FCWW-1:0]   fcw_q;
  logic [1:0]        mode_q;
  logic              abort_q, run_q;
  logic [WaitW-1:0]  wait_q;
  logic [TmoW-1:0]   tmo_q;
  logic [15:0]       lock_cnt_q;
  logic              locked_q, sat_q, tmo_err_q;

  logic              req, we, ack, rbit;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              accept, run_set, run_clr, abort_pend, tmo_hit, enter_done;

  // Only bit 0 of the read data carries LOCK/SAT.
  logic unused_rdata_hi;
  assign unused_rdata_hi = m_rdata[1];

  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);
  assign abort_pend = abort_q | abort;
  assign tmo_hit    = (tmo_q >= TmoW'(TIMEOUT_CYC));

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    accept  = 1'b0;
    run_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          res_d   = ResNone;
          state_d = StWrDis;
        end
      end
      StWrDis: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = ADDR_W'(AdpllEnAddr);
        if (ack) state_d = abort_pend ? StWrOff : StWrFcw;
      end
      StWrFcw: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_W'(FcwAddr);
        wdata = DATA_W'(fcw_q);
        if (ack) state_d = abort_pend ? StWrOff : StWrMode;
      end
      StWrMode: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_W'(AdpllModeAddr);
        wdata = DATA_W'(mode_q);
        if (ack) state_d = abort_pend ? StWrOff : StWrEn;
      end
      StWrEn: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_W'(AdpllEnAddr);
        wdata = DATA_W'(1);
        if (ack) begin
          run_set = !abort_pend;
          state_d = abort_pend ? StWrOff : StSettle;
        end
      end
      StSettle, StGap: begin
        if (abort_pend) begin
          state_d = StWrOff;
        end else if (tmo_hit) begin
          res_d   = ResTmo;
          state_d = StWrOff;
        end else if (state_q == StSettle && wait_q == WaitW'(SETTLE_CYC - 1)) begin
          state_d = StRdSat;
        end else if (state_q == StGap && wait_q == WaitW'(POLL_GAP - 1)) begin
          state_d = StRdSat;
        end
      end
      StRdSat: begin
        req  = 1'b1;
        addr = ADDR_W'(AdpllSatAddr);
        if (ack) begin
          if (abort_pend) begin
            state_d = StWrOff;
          end else if (rbit) begin
            res_d   = ResSat;
            state_d = StWrOff;
          end else if (tmo_hit) begin
            res_d   = ResTmo;
            state_d = StWrOff;
          end else begin
            state_d = StRdLock;
          end
        end
      end
      StRdLock: begin
        req  = 1'b1;
        addr = ADDR_W'(AdpllLockAddr);
        if (ack) begin
          if (abort_pend) begin
            state_d = StWrOff;
          end else if (rbit) begin
            res_d   = ResLock;
            state_d = StDone;
          end else if (tmo_hit) begin
            res_d   = ResTmo;
            state_d = StWrOff;
          end else begin
            state_d = StGap;
          end
        end
      end
      StWrOff: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = ADDR_W'(AdpllEnAddr);
        if (ack) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign run_clr    = (state_d == StWrOff) || (state_d == StDone);
  assign enter_done = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      res_q      <= ResNone;
      fcw_q      <= '0;
      mode_q     <= '0;
      abort_q    <= 1'b0;
      run_q      <= 1'b0;
      wait_q     <= '0;
      tmo_q      <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      sat_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;

      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (state_q == StSettle || state_q == StGap) begin
        wait_q <= wait_q + WaitW'(1);
      end

      if (accept) begin
        fcw_q     <= fcw_in;
        mode_q    <= mode_in;
        abort_q   <= 1'b0;
        locked_q  <= 1'b0;
        sat_q     <= 1'b0;
        tmo_err_q <= 1'b0;
      end else if (abort && busy) begin
        abort_q <= 1'b1;
      end

      // Both counters run from the EN=1 ack; the lock-read ack cycle itself is counted.
      if (accept) begin
        run_q      <= 1'b0;
        tmo_q      <= '0;
        lock_cnt_q <= '0;
      end else if (run_set) begin
        run_q      <= 1'b1;
        tmo_q      <= '0;
        lock_cnt_q <= '0;
      end else if (run_q) begin
        lock_cnt_q <= sat_inc16(lock_cnt_q);
        if (!tmo_hit) tmo_q <= tmo_q + TmoW'(1);
        if (run_clr) run_q <= 1'b0;
      end

      if (enter_done) begin
        locked_q  <= !abort_pend && (res_d == ResLock);
        sat_q     <= !abort_pend && (res_d == ResSat);
        tmo_err_q <= !abort_pend && (res_d == ResTmo);
      end
    end
  end

  assign locked      = locked_q;
  assign sat_err     = sat_q;
  assign tmo_err     = tmo_err_q;
  assign lock_cycles = lock_cnt_q;

  adpll_bus_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bus_master (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .rbit     (rbit),
    .m_valid  (m_valid),
    .m_address(m_address),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rbit   (m_rdata[0]),
    .m_ready  (m_ready)
  );

endmodule

// File: tb/tb_adpll_hop_seq.sv
// Bench for adpll_hop_seq: behavioural ADPLL register slave, write/result scoreboard and a
// bus protocol monitor.
module tb_adpll_hop_seq;
  import adpll_hop_seq_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] fcw_in = '0;
  logic [1:0]    mode_in = '0;
  logic          busy, done, locked, sat_err, tmo_err;
  logic [15:0]   lock_cycles;
  logic          m_valid, m_wstrb;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_rdata;
  logic          m_ready = 1'b0;

  always #5 clk = ~clk;

  adpll_hop_seq #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FCWW       (FW),
    .SETTLE_CYC (64),
    .POLL_GAP   (8),
    .TIMEOUT_CYC(512)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .fcw_in     (fcw_in),
    .mode_in    (mode_in),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .sat_err    (sat_err),
    .tmo_err    (tmo_err),
    .lock_cycles(lock_cycles),
    .m_valid    (m_valid),
    .m_address  (m_address),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADPLL slave model: ready is a (optionally delayed) registered copy of valid.
  int unsigned   ready_delay = 0;
  int unsigned   lock_delay  = 200;
  int unsigned   sat_on_poll = 0;
  logic          en_r = 1'b0;
  int unsigned   en_cyc = 0;
  int unsigned   sat_cnt = 0;
  int unsigned   dly = 0;
  int unsigned   cyc = 0;
  logic [FW-1:0] fcw_r = '0;
  logic [1:0]    mode_r = '0;
  logic          rd_bit;

  always_comb begin
    rd_bit = 1'b0;
    if (m_address == AdpllLockAddr) rd_bit = en_r && (en_cyc >= lock_delay);
    else if (m_address == AdpllSatAddr) rd_bit = (sat_on_poll != 0) && (sat_cnt + 1 == sat_on_poll);
  end
  assign m_rdata = {1'b0, rd_bit};

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_ready <= m_valid && (dly >= ready_delay);
    dly     <= m_valid ? dly + 1 : 0;
    if (en_r) en_cyc <= en_cyc + 1;
    if (m_valid && m_ready && m_wstrb) begin
      case (m_address)
        AdpllEnAddr: begin
          en_r    <= m_wdata[0];
          en_cyc  <= 0;
          sat_cnt <= 0;
        end
        FcwAddr:       fcw_r  <= m_wdata[FW-1:0];
        AdpllModeAddr: mode_r <= m_wdata[1:0];
        default: ;
      endcase
    end else if (m_valid && m_ready && m_address == AdpllSatAddr) begin
      sat_cnt <= sat_cnt + 1;
    end
  end

  logic [AW+DW-1:0] exp_wr_q[$];
  logic [2:0]       exp_res_q[$];
  int               n_done = 0;
  int               n_sat_rd = 0;
  int               n_lock_rd = 0;
  int unsigned      en_ack_cyc = 0;
  int unsigned      lock_ack_cyc = 0;

  task automatic monitor();
    logic             vprev = 1'b0;
    logic             cprev = 1'b0;
    logic [AW+DW:0]   bprev = '0;
    logic [AW-1:0]    next_rd = AdpllSatAddr;
    logic [AW+DW-1:0] ew;
    logic [2:0]       er;
    forever begin
      @(negedge clk);
      if (rst) begin
        vprev = 1'b0;
        cprev = 1'b0;
        continue;
      end
      if (cprev) check_eq("valid_drop_after_ack", 64'(m_valid), 64'(0));
      else if (m_valid && !vprev) check_eq("no_valid_in_recover", 64'(m_ready), 64'(0));
      else if (m_valid && vprev) check_eq("bus_stable", 64'({m_address, m_wdata, m_wstrb}), 64'(bprev));
      if (m_valid && m_ready) begin
        if (m_wstrb) begin
          if (exp_wr_q.size() > 0) ew = exp_wr_q.pop_front();
          else ew = '1;
          check_eq("write", 64'({m_address, m_wdata}), 64'(ew));
          if (m_address == AdpllEnAddr && m_wdata == DW'(1)) begin
            en_ack_cyc = cyc;
            next_rd    = AdpllSatAddr;
          end
        end else begin
          check_eq("read_addr", 64'(m_address), 64'(next_rd));
          if (m_address == AdpllSatAddr) begin
            n_sat_rd++;
            next_rd = AdpllLockAddr;
          end else begin
            n_lock_rd++;
            next_rd = AdpllSatAddr;
            if (m_rdata[0]) lock_ack_cyc = cyc;
          end
        end
      end
      if (done) begin
        n_done++;
        if (exp_res_q.size() > 0) er = exp_res_q.pop_front();
        else er = 3'b111;
        check_eq("flags_at_done", 64'({locked, sat_err, tmo_err}), 64'(er));
        check_eq("busy_low_in_done", 64'(busy), 64'(0));
      end
      vprev = m_valid;
      cprev = m_valid && m_ready;
      bprev = {m_address, m_wdata, m_wstrb};
    end
  endtask

  task automatic push_hop(input logic [FW-1:0] f, input logic [1:0] md, input logic off,
                          input logic with_res, input logic [2:0] res);
    exp_wr_q.push_back({AdpllEnAddr, DW'(0)});
    exp_wr_q.push_back({FcwAddr, DW'(f)});
    exp_wr_q.push_back({AdpllModeAddr, DW'(md)});
    exp_wr_q.push_back({AdpllEnAddr, DW'(1)});
    if (off) exp_wr_q.push_back({AdpllEnAddr, DW'(0)});
    if (with_res) exp_res_q.push_back(res);
  endtask

  task automatic pulse_start(input logic [FW-1:0] f, input logic [1:0] md, input logic ab);
    @(negedge clk);
    start   = 1'b1;
    abort   = ab;
    fcw_in  = f;
    mode_in = md;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check_eq("done_once", 64'(n_done - d0), 64'(1));
    check_eq("writes_consumed", 64'(exp_wr_q.size()), 64'(0));
    check_eq("idle_after_hop", 64'(busy), 64'(0));
  endtask

  initial begin
    int s0, l0;
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_flags", 64'({locked, sat_err, tmo_err}), 64'(0));
    check_eq("rst_valid", 64'(m_valid), 64'(0));
    check_eq("rst_addr_wdata", 64'({m_address, m_wdata, m_wstrb}), 64'(0));
    check_eq("rst_lock_cycles", 64'(lock_cycles), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_abort_busy", 64'(busy), 64'(0));
    check_eq("idle_abort_valid", 64'(m_valid), 64'(0));
    check_eq("idle_abort_done", 64'(n_done), 64'(0));

    // nominal hop
    push_hop(26'h2620000, 2'd1, 1'b0, 1'b1, 3'b100);
    pulse_start(26'h2620000, 2'd1, 1'b0);
    wait_done(3000);
    check_eq("lock_cycles_exact", 64'(lock_cycles), 64'(lock_ack_cyc - en_ack_cyc));
    check_eq("lock_cycles_ge_delay", 64'(lock_cycles >= 16'd200), 64'(1));
    check_eq("lock_cycles_near_delay", 64'(lock_cycles <= 16'd230), 64'(1));
    check_eq("slave_fcw", 64'(fcw_r), 64'(26'h2620000));
    check_eq("slave_mode", 64'(mode_r), 64'(1));

    // start and abort together in idle: start wins; slave ready delayed
    ready_delay = 3;
    lock_delay  = 120;
    push_hop(26'h1555555, 2'd2, 1'b0, 1'b1, 3'b100);
    pulse_start(26'h1555555, 2'd2, 1'b1);
    wait_done(3000);
    check_eq("slow_lock_cycles", 64'(lock_cycles), 64'(lock_ack_cyc - en_ack_cyc));

    // timeout: lock never asserts
    ready_delay = 0;
    lock_delay  = 32'hFFFF_FFFF;
    push_hop(26'h0ABCDEF, 2'd3, 1'b1, 1'b1, 3'b001);
    pulse_start(26'h0ABCDEF, 2'd3, 1'b0);
    wait_done(3000);
    check_eq("tmo_en_off", 64'(en_r), 64'(0));

    // saturation on the third SAT poll
    sat_on_poll = 3;
    s0 = n_sat_rd;
    l0 = n_lock_rd;
    push_hop(26'h0123456, 2'd0, 1'b1, 1'b1, 3'b010);
    pulse_start(26'h0123456, 2'd0, 1'b0);
    wait_done(3000);
    check_eq("sat_polls", 64'(n_sat_rd - s0), 64'(3));
    check_eq("lock_polls", 64'(n_lock_rd - l0), 64'(2));
    sat_on_poll = 0;

    // abort during the FCW write, with a start attempt while busy
    exp_wr_q.push_back({AdpllEnAddr, DW'(0)});
    exp_wr_q.push_back({FcwAddr, DW'(26'h0F0F0F0)});
    exp_wr_q.push_back({AdpllEnAddr, DW'(0)});
    exp_res_q.push_back(3'b000);
    pulse_start(26'h0F0F0F0, 2'd1, 1'b0);
    for (int i = 0; i < 100 && !(m_valid && m_address == FcwAddr); i++) @(negedge clk);
    check_eq("saw_fcw_access", 64'(m_valid && m_address == FcwAddr), 64'(1));
    abort  = 1'b1;
    start  = 1'b1;
    fcw_in = 26'h3FFFFFF;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    wait_done(500);
    check_eq("abort_fcw_kept", 64'(fcw_r), 64'(26'h0F0F0F0));

    // reset while in the poll gap, then a clean hop
    lock_delay = 32'hFFFF_FFFF;
    l0 = n_lock_rd;
    push_hop(26'h2000001, 2'd1, 1'b0, 1'b0, 3'b000);
    pulse_start(26'h2000001, 2'd1, 1'b0);
    for (int i = 0; i < 2000 && n_lock_rd == l0; i++) @(negedge clk);
    check_eq("saw_lock_poll", 64'(n_lock_rd - l0 > 0), 64'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_gap_busy", 64'(busy), 64'(0));
    check_eq("rst_gap_valid", 64'(m_valid), 64'(0));
    check_eq("rst_gap_flags", 64'({locked, sat_err, tmo_err, done}), 64'(0));
    check_eq("rst_gap_writes", 64'(exp_wr_q.size()), 64'(0));
    rst = 1'b0;
    exp_res_q.delete();
    lock_delay = 150;
    push_hop(26'h2620000, 2'd1, 1'b0, 1'b1, 3'b100);
    pulse_start(26'h2620000, 2'd1, 1'b0);
    wait_done(3000);
    check_eq("post_rst_lock_cycles", 64'(lock_cycles), 64'(lock_ack_cyc - en_ack_cyc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
